// File: rtl/line_buffer.sv
// Single-line pixel store for a 3x3 sliding-window pipeline: one pixel written per
// valid cycle, three adjacent pixels from the read pointer presented combinationally.
module line_buffer #(
    parameter int IMAGE_WIDTH = 512,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_data_valid,
    input  logic                    rd_enable,
    output logic [3*DATA_WIDTH-1:0] o_data
);

    localparam int PTR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(IMAGE_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [IMAGE_WIDTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      rd_idx1, rd_idx2;

    // Explicit compare keeps wrap correct for widths that are not a power of two.
    function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_data_valid) begin
            wr_ptr_d = inc_wrap(wr_ptr_q);
        end
        if (rd_enable) begin
            rd_ptr_d = inc_wrap(rd_ptr_q);
        end
    end

    assign rd_idx1 = inc_wrap(rd_ptr_q);
    assign rd_idx2 = inc_wrap(rd_idx1);

    always_ff @(posedge clk) begin
        if (rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < IMAGE_WIDTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (i_data_valid) begin
                mem_q[wr_ptr_q] <= i_data;
            end
        end
    end

    // No write bypass: a write into the window becomes visible only after the edge.
    assign o_data = {mem_q[rd_ptr_q], mem_q[rd_idx1], mem_q[rd_idx2]};

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer: constant vector table, directed fill/wrap/overwrite
// sequences, then random traffic checked against an array-based line model.
module tb_line_buffer;

    localparam int W  = 512;
    localparam int DW = 8;

    logic            clk;
    logic            rstN;
    logic [DW-1:0]   i_data;
    logic            i_data_valid;
    logic            rd_enable;
    logic [3*DW-1:0] o_data;

    int n_cmp;
    int n_fail;

    // Reference model: plain array plus integer pointers with modulo arithmetic.
    int m_mem [W];
    int m_wr;
    int m_rd;

    logic [3*DW-1:0] exp_q [$];

    typedef struct {
        string         name;
        logic          rst;
        logic          valid;
        logic [DW-1:0] data;
        logic          rd;
        logic [3*DW-1:0] exp;
    } vec_t;

    vec_t vecs [14];

    line_buffer #(.IMAGE_WIDTH(W), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .rd_enable    (rd_enable),
        .o_data       (o_data)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3*DW-1:0] model_out();
        logic [DW-1:0] a, b, c;
        a = DW'(m_mem[m_rd]);
        b = DW'(m_mem[(m_rd + 1) % W]);
        c = DW'(m_mem[(m_rd + 2) % W]);
        return {a, b, c};
    endfunction

    task automatic model_step(input logic rst, input logic valid, input logic [DW-1:0] data,
                              input logic rd);
        if (rst) begin
            for (int i = 0; i < W; i++) m_mem[i] = 0;
            m_wr = 0;
            m_rd = 0;
        end else begin
            if (valid) begin
                m_mem[m_wr] = int'(data);
                m_wr = (m_wr + 1) % W;
            end
            if (rd) m_rd = (m_rd + 1) % W;
        end
    endtask

    // Driver: apply inputs for one rising edge, then settle 1 time unit past it.
    task automatic step(input logic rst, input logic valid, input logic [DW-1:0] data,
                        input logic rd);
        rstN         = rst;
        i_data_valid = valid;
        i_data       = data;
        rd_enable    = rd;
        @(posedge clk);
        #1;
        model_step(rst, valid, data, rd);
        rstN         = 1'b0;
        i_data_valid = 1'b0;
        rd_enable    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: o_data=0x%06h expected=0x%06h", name, act, exp);
        end
    endtask

    // Scoreboard check against the reference model through the expected queue.
    task automatic sb_check(input string name);
        logic [3*DW-1:0] e;
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        chk(name, o_data, e);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rstN = 1'b0;
        i_data = '0;
        i_data_valid = 1'b0;
        rd_enable = 1'b0;
        for (int i = 0; i < W; i++) m_mem[i] = 0;
        m_wr = 0;
        m_rd = 0;

        vecs[0]  = '{"reset_ignores_write", 1'b1, 1'b1, 8'hAA, 1'b0, 24'h000000};
        vecs[1]  = '{"first_write_at_0",    1'b0, 1'b1, 8'h10, 1'b0, 24'h100000};
        vecs[2]  = '{"gap_hold_1",          1'b0, 1'b0, 8'hEE, 1'b0, 24'h100000};
        vecs[3]  = '{"write_20",            1'b0, 1'b1, 8'h20, 1'b0, 24'h102000};
        vecs[4]  = '{"gap_hold_2",          1'b0, 1'b0, 8'hEE, 1'b0, 24'h102000};
        vecs[5]  = '{"write_30",            1'b0, 1'b1, 8'h30, 1'b0, 24'h102030};
        vecs[6]  = '{"idle_1",              1'b0, 1'b0, 8'h00, 1'b0, 24'h102030};
        vecs[7]  = '{"idle_2",              1'b0, 1'b0, 8'h00, 1'b0, 24'h102030};
        vecs[8]  = '{"idle_3",              1'b0, 1'b0, 8'h00, 1'b0, 24'h102030};
        vecs[9]  = '{"idle_4",              1'b0, 1'b0, 8'h00, 1'b0, 24'h102030};
        vecs[10] = '{"idle_5",              1'b0, 1'b0, 8'h00, 1'b0, 24'h102030};
        vecs[11] = '{"read_advance",        1'b0, 1'b0, 8'h00, 1'b1, 24'h203000};
        vecs[12] = '{"reset_mid_stream",    1'b1, 1'b1, 8'h77, 1'b1, 24'h000000};
        vecs[13] = '{"after_reset_idle",    1'b0, 1'b0, 8'h00, 1'b0, 24'h000000};

        for (int v = 0; v < 14; v++) begin
            step(vecs[v].rst, vecs[v].valid, vecs[v].data, vecs[v].rd);
            chk(vecs[v].name, o_data, vecs[v].exp);
        end

        // Fill a full line and read it out across the wrap.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        chk("fill_window_0", o_data, 24'h000102);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("read_1", o_data, 24'h010203);
        for (int i = 1; i < 100; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("read_100", o_data, 24'h646566);
        for (int i = 100; i < W - 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("read_510_wrap", o_data, 24'hFEFF00);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("read_511_wrap", o_data, 24'hFF0001);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("read_ptr_wrap_0", o_data, 24'h000102);

        // Write pointer has wrapped to 0: overwrite oldest entry under the window.
        step(1'b0, 1'b1, 8'h55, 1'b0);
        chk("overwrite_entry_0", o_data, 24'h550102);

        // Concurrent read and write, then locate both pointers.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'(8'hA0 + i), 1'b1);
        chk("concurrent_rd_at_10", o_data, 24'h000000);
        step(1'b0, 1'b1, 8'hC3, 1'b0);
        chk("concurrent_wr_at_10", o_data, 24'hC30000);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("reset_clears", o_data, 24'h000000);
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        chk("reset_wr_ptr_0", o_data, 24'h5A0000);

        // Random traffic against the model, with occasional resets.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic r, v, rd;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0);
            d  = DW'($urandom);
            step(r, v, d, rd);
            sb_check("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
